// File: rtl/gold_pkg.sv
// gold_pkg: shared constants, sync FSM state type and the reference Gold sequence.
package gold_pkg;
  localparam int LENGTH = 63;
  localparam int POLY_LEN = $clog2(LENGTH);
  localparam int CORR_W = $clog2(LENGTH + 1);
  typedef enum logic {SEARCH, LOCK} sync_state_t;
  // Preferred pair x^6+x+1 and x^6+x^5+x^2+x+1, both seeded all-ones; chip 0 ends up in the MSB.
  function automatic logic [LENGTH-1:0] gold_seq();
    logic [POLY_LEN-1:0] a;
    logic [POLY_LEN-1:0] b;
    logic [LENGTH-1:0] s;
    a = '1;
    b = '1;
    s = '0;
    for (int i = 0; i < LENGTH; i++) begin
      s = {s[LENGTH-2:0], a[0] ^ b[0]};
      a = {a[0] ^ a[1], a[POLY_LEN-1:1]};
      b = {b[0] ^ b[1] ^ b[2] ^ b[5], b[POLY_LEN-1:1]};
    end
    return s;
  endfunction
  localparam logic [LENGTH-1:0] GOLD_REF = gold_seq();
endpackage

// File: rtl/gold_popcount.sv
// gold_popcount: population count of an N-bit vector as a recursive adder tree.
module gold_popcount
  import gold_pkg::*;
#(
  parameter int N = LENGTH,
  parameter int W = CORR_W
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_cnt
);
  if (N == 1) begin : g_leaf
    assign o_cnt = W'(i_vec);
  end else begin : g_node
    localparam int H = N / 2;
    logic [W-1:0] w_lo;
    logic [W-1:0] w_hi;
    gold_popcount #(.N(H), .W(W)) u_lo (.i_vec(i_vec[H-1:0]), .o_cnt(w_lo));
    gold_popcount #(.N(N - H), .W(W)) u_hi (.i_vec(i_vec[N-1:H]), .o_cnt(w_hi));
    assign o_cnt = w_lo + w_hi;
  end
endmodule

// File: rtl/gold_corr_sync.sv
// gold_corr_sync: sliding-window Gold-code correlator with SEARCH/LOCK phase tracking.
// Define GOLD_BIT_ERR_CNT_EN to build the saturating in-lock chip error counter.
module gold_corr_sync
  import gold_pkg::*;
#(
  parameter int THRESH = 57,
  parameter int MISS_MAX = 2,
  parameter logic [LENGTH-1:0] REF_SEQ = GOLD_REF
) (
  input  logic                clkin,
  input  logic                rstn,
  input  logic                chip_en,
  input  logic                code_gold,
  output logic                sync_lock,
  output logic                peak,
  output logic [CORR_W-1:0]   corr,
  output logic [POLY_LEN-1:0] phase,
  output logic [15:0]         bit_err_cnt
);
  localparam int MW = $clog2(MISS_MAX + 1);
  logic [LENGTH-1:0] r_shreg;
  logic [CORR_W-1:0] r_fill;
  logic [MW-1:0] r_miss;
  sync_state_t r_state;
  logic [LENGTH-1:0] w_shreg_nx;
  logic [CORR_W-1:0] w_mis;
  logic [CORR_W-1:0] w_agree;
  logic [POLY_LEN-1:0] w_phase_inc;
  logic w_full;
  logic w_hit;
  logic w_bound;
  sync_state_t w_state_nx;
  logic [MW-1:0] w_miss_nx;
  logic [POLY_LEN-1:0] w_phase_nx;
  logic w_peak_nx;
  assign w_shreg_nx = {r_shreg[LENGTH-2:0], code_gold};
  gold_popcount u_pop (.i_vec(w_shreg_nx ^ REF_SEQ), .o_cnt(w_mis));
  assign w_agree = CORR_W'(LENGTH) - w_mis;
  assign w_full = chip_en && (r_fill >= CORR_W'(LENGTH - 1));
  assign w_hit = w_full && (w_agree >= CORR_W'(THRESH));
  assign w_phase_inc = (phase == POLY_LEN'(LENGTH - 1)) ? '0 : phase + 1'b1;
  assign w_bound = (w_phase_inc == POLY_LEN'(LENGTH - 1));
  always_comb begin
    w_state_nx = r_state;
    w_miss_nx = r_miss;
    w_phase_nx = phase;
    w_peak_nx = 1'b0;
    if (chip_en && r_state == SEARCH && w_hit) begin
      w_state_nx = LOCK;
      w_miss_nx = '0;
      w_phase_nx = POLY_LEN'(LENGTH - 1);
      w_peak_nx = 1'b1;
    end else if (chip_en && r_state == LOCK) begin
      w_phase_nx = w_phase_inc;
      // Only the period boundary is judged; peaks at other offsets are false alignments.
      if (w_bound && w_hit) begin
        w_peak_nx = 1'b1;
        w_miss_nx = '0;
      end else if (w_bound && r_miss == MW'(MISS_MAX - 1)) begin
        w_state_nx = SEARCH;
        w_miss_nx = '0;
        w_phase_nx = '0;
      end else if (w_bound) begin
        w_miss_nx = r_miss + 1'b1;
      end
    end
  end
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_shreg <= '0;
      r_fill <= '0;
      r_miss <= '0;
      r_state <= SEARCH;
      sync_lock <= 1'b0;
      peak <= 1'b0;
      corr <= '0;
      phase <= '0;
    end else begin
      r_state <= w_state_nx;
      r_miss <= w_miss_nx;
      phase <= w_phase_nx;
      peak <= w_peak_nx;
      sync_lock <= (w_state_nx == LOCK);
      if (chip_en) r_shreg <= w_shreg_nx;
      if (chip_en && r_fill != CORR_W'(LENGTH)) r_fill <= r_fill + 1'b1;
      if (w_full) corr <= w_agree;
    end
  end
`ifdef GOLD_BIT_ERR_CNT_EN
  logic [15:0] r_err;
  logic [POLY_LEN-1:0] w_idx;
  logic w_err;
  assign w_idx = POLY_LEN'(LENGTH - 1) - w_phase_inc;
  assign w_err = chip_en && (r_state == LOCK) && (code_gold != REF_SEQ[w_idx]);
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) r_err <= '0;
    else if (w_err && r_err != 16'hFFFF) r_err <= r_err + 1'b1;
  end
  assign bit_err_cnt = r_err;
`else
  assign bit_err_cnt = '0;
`endif
endmodule

// File: tb/tb_gold_corr_sync.sv
// tb_gold_corr_sync: directed chip streams with a per-chip expectation queue and a decoupled monitor.
module tb_gold_corr_sync;
  import gold_pkg::*;
  typedef struct {
    bit pk;
    bit lk;
    int ph;
    int co;
    int er;
  } exp_t;
`ifdef GOLD_BIT_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clkin = 1'b0;
  logic rstn = 1'b0;
  logic chip_en = 1'b0;
  logic code_gold = 1'b0;
  logic sync_lock;
  logic peak;
  logic [CORR_W-1:0] corr;
  logic [POLY_LEN-1:0] phase;
  logic [15:0] bit_err_cnt;
  logic [LENGTH-1:0] ref_v = GOLD_REF;
  exp_t q[$];
  exp_t e;
  int n_vec = 0;
  int n_err = 0;
  int zc;

  gold_corr_sync dut (
    .clkin(clkin), .rstn(rstn), .chip_en(chip_en), .code_gold(code_gold),
    .sync_lock(sync_lock), .peak(peak), .corr(corr), .phase(phase), .bit_err_cnt(bit_err_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input bit b, input bit pk, input bit lk, input int ph, input int co,
                      input int er, input int gap);
    chip_en = 1'b1;
    code_gold = b;
    q.push_back('{pk, lk, ph, co, (ERR_EN ? er : 0)});
    @(negedge clkin);
    chip_en = 1'b0;
    repeat (gap) @(negedge clkin);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clkin);
    rstn = 1'b1;
  endtask

  always @(posedge clkin) begin
    if (rstn && chip_en) begin
      #2;
      chk("pending", (q.size() > 0) ? 1 : 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("peak", int'(peak), int'(e.pk));
        chk("sync_lock", int'(sync_lock), int'(e.lk));
        if (e.ph >= 0) chk("phase", int'(phase), e.ph);
        if (e.co >= 0) chk("corr", int'(corr), e.co);
        if (e.er >= 0) chk("bit_err_cnt", int'(bit_err_cnt), e.er);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clkin);
    chk("rst_sync_lock", int'(sync_lock), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_corr", int'(corr), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_err", int'(bit_err_cnt), 0);
    rstn = 1'b1;
    @(negedge clkin);
    // acquisition, back-to-back chips
    for (int k = 0; k < LENGTH; k++)
      send(ref_v[62-k], k == 62, k == 62, (k == 62) ? 62 : 0, (k == 62) ? 63 : 0, 0, 0);
    // tracking with chip_en every third cycle
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < LENGTH; k++)
        send(ref_v[62-k], k == 62, 1'b1, k, (k == 62) ? 63 : -1, 0, 2);
    // three flipped chips per period while locked
    zc = 0;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < LENGTH; k++) begin
        bit f;
        f = (k == 10) || (k == 20) || (k == 30);
        zc += int'(f);
        send(ref_v[62-k] ^ f, k == 62, 1'b1, k, (k == 62) ? 60 : -1, zc, 0);
      end
    // all-zero chips: two missed boundaries drop the lock
    for (int k = 0; k < LENGTH; k++)
      send(1'b0, 1'b0, 1'b1, k, (k == 62) ? 63 - $countones(ref_v) : -1, -1, 0);
    for (int k = 0; k < LENGTH; k++)
      send(1'b0, 1'b0, k != 62, (k == 62) ? 0 : k, (k == 62) ? 63 - $countones(ref_v) : -1, -1, 0);
    // re-acquire from SEARCH
    for (int k = 0; k < LENGTH; k++)
      send(ref_v[62-k], k == 62, k == 62, (k == 62) ? 62 : 0, (k == 62) ? 63 : -1, -1, 0);
    // asynchronous reset mid-period while locked
    for (int k = 0; k < 20; k++)
      send(ref_v[62-k], 1'b0, 1'b1, k, -1, -1, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_sync_lock", int'(sync_lock), 0);
    chk("async_peak", int'(peak), 0);
    chk("async_corr", int'(corr), 0);
    chk("async_phase", int'(phase), 0);
    chk("async_err", int'(bit_err_cnt), 0);
    @(negedge clkin);
    rstn = 1'b1;
    for (int k = 0; k < LENGTH; k++)
      send(ref_v[62-k], k == 62, k == 62, (k == 62) ? 62 : 0, (k == 62) ? 63 : 0, 0, 0);
    // seven flipped chips: 56 agreements, below threshold
    do_reset();
    for (int k = 0; k < LENGTH; k++)
      send(ref_v[62-k] ^ (k < 7), 1'b0, 1'b0, 0, (k == 62) ? 56 : 0, 0, 0);
    // six flipped chips: exactly at threshold
    do_reset();
    for (int k = 0; k < LENGTH; k++)
      send(ref_v[62-k] ^ (k < 6), k == 62, k == 62, (k == 62) ? 62 : 0, (k == 62) ? 57 : 0, 0, 0);
    repeat (5) @(negedge clkin);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
